// File: rtl/mips_multicycle_ctrl_if.sv
// Bundles the control unit's signals to and from the multicycle MIPS datapath.
// master: the control unit. It drives the enables and selects, and reads
//         opcode, zero and mem_ready.
// slave:  the datapath. It is the mirror image of master.
// Handshake: mem_ready is a level held by memory. The FSM holds its current
// memory state, with the strobe asserted, until it sees mem_ready = 1 on a
// rising clock edge. That edge completes the access.
interface mips_multicycle_ctrl_if #(
  parameter int OPCODE_WIDTH = 6
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    zero;
  logic                    mem_ready;
  logic                    IorD;
  logic                    MemRead;
  logic                    MemWrite;
  logic                    IRWrite;
  logic [1:0]              RegDst;
  logic [1:0]              MemtoReg;
  logic                    RegWrite;
  logic                    ALUSrcA;
  logic [1:0]              ALUSrcB;
  logic [1:0]              ALUOp;
  logic [1:0]              PCSrc;
  logic                    PCWrite;
  logic                    PCWriteCond;

  modport master (
    input  opcode, zero, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, PCWriteCond
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, PCWriteCond
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath.
// Each clock performs one micro-step. Memory states stall while mem_ready = 0.
// The optional jal support is enabled with the macro MIPS_CTRL_JAL_EN.
// All outputs are decoded from the current state. The only exception is
// FETCH: there IRWrite and PCWrite follow mem_ready, so the instruction is
// latched in the cycle the memory delivers it.
module mips_multicycle_ctrl #(
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus,
  output logic [STATE_WIDTH-1:0] state_dbg
);

  typedef enum logic [STATE_WIDTH-1:0] {
    S_IDLE   = STATE_WIDTH'(0),
    S_FETCH  = STATE_WIDTH'(1),
    S_DECODE = STATE_WIDTH'(2),
    S_MEMADR = STATE_WIDTH'(3),
    S_MEMRD  = STATE_WIDTH'(4),
    S_MEMWB  = STATE_WIDTH'(5),
    S_MEMWR  = STATE_WIDTH'(6),
    S_EXEC   = STATE_WIDTH'(7),
    S_ALUWB  = STATE_WIDTH'(8),
    S_BRANCH = STATE_WIDTH'(9),
    S_ADDIEX = STATE_WIDTH'(10),
    S_ADDIWB = STATE_WIDTH'(11),
`ifdef MIPS_CTRL_JAL_EN
    S_JAL    = STATE_WIDTH'(13),
`endif
    S_JUMP   = STATE_WIDTH'(12)
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'h00);
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'h02);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'h04);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'h08);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'h23);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'h2B);
`ifdef MIPS_CTRL_JAL_EN
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = OPCODE_WIDTH'(6'h03);
`endif

  state_t state_q;
  state_t state_d;

  // The zero flag is gated with PCWriteCond in the datapath, not here.
  logic unused_zero;
  assign unused_zero = bus.zero;

  // Next-state logic: memory states wait for mem_ready; DECODE and MEMADR route on opcode.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_JAL_EN
          OP_JAL:       state_d = S_JAL;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register; reset is synchronous and returns to IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Output decode: every enable defaults low; each state raises only its own micro-step.
  always_comb begin
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 2'b00;
    bus.MemtoReg    = 2'b00;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSrc       = 2'b00;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE: bus.ALUSrcB = 2'b11;
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 2'b01;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'b01;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCSrc       = 2'b01;
        bus.PCWriteCond = 1'b1;
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_ADDIWB: bus.RegWrite = 1'b1;
      S_JUMP: begin
        bus.PCWrite = 1'b1;
        bus.PCSrc   = 2'b10;
      end
`ifdef MIPS_CTRL_JAL_EN
      // $31 <= PC+4 and the PC jumps in the same cycle.
      S_JAL: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'b10;
        bus.MemtoReg = 2'b10;
        bus.PCWrite  = 1'b1;
        bus.PCSrc    = 2'b10;
      end
`endif
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl. The reference model works per instruction:
// each opcode maps to the list of micro-steps it walks after FETCH, and
// memory steps repeat while mem_ready is low. Expected outputs for each step
// come straight from the control table. Directed sequences use literal
// expectations; a randomized run follows. Define MIPS_CTRL_JAL_EN for both
// the bench and the RTL to exercise jal.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state_dbg;

  mips_multicycle_ctrl_if #(.OPCODE_WIDTH(6)) bus();

  mips_multicycle_ctrl #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Output vector layout:
  //  [17] IorD  [16] MemRead  [15] MemWrite  [14] IRWrite  [13:12] RegDst
  //  [11:10] MemtoReg  [9] RegWrite  [8] ALUSrcA  [7:6] ALUSrcB  [5:4] ALUOp
  //  [3:2] PCSrc  [1] PCWrite  [0] PCWriteCond
  localparam logic [17:0] WRITE_MASK = 18'h0C203;

  logic [21:0] exp_q[$];
  int          path_q[$];
  int          exp_st;
  bit          model_ok = 0;
  logic [3:0]  s_state;
  logic [17:0] s_out;

  function automatic logic [17:0] mk(logic iord, logic mr, logic mw, logic ir,
      logic [1:0] rd, logic [1:0] m2r, logic rw, logic asa, logic [1:0] asb,
      logic [1:0] aop, logic [1:0] pcs, logic pcw, logic pcwc);
    return {iord, mr, mw, ir, rd, m2r, rw, asa, asb, aop, pcs, pcw, pcwc};
  endfunction

  function automatic logic [17:0] dut_outs();
    return {bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
            bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
            bus.PCSrc, bus.PCWrite, bus.PCWriteCond};
  endfunction

  // Control table: outputs of each micro-step.
  function automatic logic [17:0] exp_outs(int st, logic rdy);
    case (st)
      1:  return mk(0, 1, 0, rdy, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, rdy, 0);
      2:  return mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
      3:  return mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
      4:  return mk(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      5:  return mk(0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      6:  return mk(1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      7:  return mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0);
      8:  return mk(0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      9:  return mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b01, 2'b01, 0, 1);
      10: return mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
      11: return mk(0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
      12: return mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0);
      13: return mk(0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 2'b00, 2'b10, 1, 0);
      default: return 18'h0;
    endcase
  endfunction

  // Micro-steps an instruction walks after its fetch completes.
  function automatic void plan(logic [5:0] op);
    path_q.delete();
    path_q.push_back(2);
    case (op)
      6'h23: begin path_q.push_back(3); path_q.push_back(4); path_q.push_back(5); end
      6'h2B: begin path_q.push_back(3); path_q.push_back(6); end
      6'h00: begin path_q.push_back(7); path_q.push_back(8); end
      6'h04: path_q.push_back(9);
      6'h08: begin path_q.push_back(10); path_q.push_back(11); end
      6'h02: path_q.push_back(12);
`ifdef MIPS_CTRL_JAL_EN
      6'h03: path_q.push_back(13);
`endif
      default: ;
    endcase
  endfunction

  function automatic void model_advance(logic [5:0] op, logic rdy, logic rst);
    if (rst) begin
      exp_st   = 0;
      model_ok = 1;
      path_q.delete();
    end else if ((exp_st == 1 || exp_st == 4 || exp_st == 6) && !rdy) begin
      exp_st = exp_st;
    end else if (exp_st == 0) begin
      exp_st = 1;
    end else if (exp_st == 1) begin
      plan(op);
      exp_st = path_q.pop_front();
    end else if (path_q.size() > 0) begin
      exp_st = path_q.pop_front();
    end else begin
      exp_st = 1;
    end
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver and per-cycle scoreboard compare. Inputs change at the falling
  // edge, outputs are sampled 1 ns later, and the model advances at the
  // rising edge.
  task automatic step(input logic [5:0] op, input logic rdy, input logic rst);
    logic [21:0] e;
    @(negedge clk);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    bus.zero      = 1'($urandom_range(0, 1));
    reset         = rst;
    #1;
    s_state = state_dbg;
    s_out   = dut_outs();
    if (model_ok) begin
      exp_q.push_back({4'(exp_st), exp_outs(exp_st, rdy)});
      e = exp_q.pop_front();
      chk("model_state", 32'(s_state), 32'(e[21:18]));
      chk("model_outs", 32'(s_out), 32'(e[17:0]));
    end
    @(posedge clk);
    model_advance(op, rdy, rst);
  endtask

  int         lw_tr[6]  = '{1, 2, 3, 4, 5, 1};
  int         sw_tr[7]  = '{2, 3, 6, 6, 6, 6, 1};
  logic       sw_rdy[7] = '{1, 1, 0, 0, 0, 1, 0};
  logic [5:0] ops[9]    = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h03, 6'h3F, 6'h00};

  initial begin
    reset         = 1'b1;
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;

    // Reset for two cycles, then IDLE with every output low.
    step(6'h00, 0, 1);
    step(6'h00, 0, 1);
    step(6'h23, 1, 0);
    chk("reset_state", 32'(s_state), 0);
    chk("reset_outs", 32'(s_out), 0);

    // lw with memory always ready; the last step fetches the next sw.
    for (int i = 0; i < 6; i++) begin
      step((i == 5) ? 6'h2B : 6'h23, 1, 0);
      chk("lw_state", 32'(s_state), 32'(lw_tr[i]));
      chk("lw_regwrite", 32'(s_out[9]), (lw_tr[i] == 5) ? 1 : 0);
      chk("lw_memtoreg", 32'(s_out[11:10]), (lw_tr[i] == 5) ? 1 : 0);
      if (i == 0) begin
        chk("fetch_memread", 32'(s_out[16]), 1);
        chk("fetch_alusrcb", 32'(s_out[7:6]), 1);
      end
    end

    // sw stalled for three cycles in MEMWR; it ends in a stalled FETCH.
    for (int i = 0; i < 7; i++) begin
      step((i == 6) ? 6'h04 : 6'h2B, sw_rdy[i], 0);
      chk("sw_state", 32'(s_state), 32'(sw_tr[i]));
      chk("sw_regwrite", 32'(s_out[9]), 0);
      if (sw_tr[i] == 6) begin
        chk("sw_memwrite", 32'(s_out[15]), 1);
        chk("sw_iord", 32'(s_out[17]), 1);
      end
    end
    chk("stall_fetch_ir_0", 32'(s_out[14]), 0);
    chk("stall_fetch_pcw_0", 32'(s_out[1]), 0);

    // Second stalled FETCH cycle, then the fetch completes for beq.
    step(6'h04, 0, 0);
    chk("stall_fetch_state", 32'(s_state), 1);
    chk("stall_fetch_ir_1", 32'(s_out[14]), 0);
    chk("stall_fetch_pcw_1", 32'(s_out[1]), 0);
    step(6'h04, 1, 0);
    chk("fetch_done_ir", 32'(s_out[14]), 1);
    chk("fetch_done_pcw", 32'(s_out[1]), 1);
    step(6'h04, 1, 0);
    chk("beq_decode", 32'(s_state), 2);
    chk("beq_decode_ir", 32'(s_out[14]), 0);
    step(6'h3F, 1, 0);
    chk("beq_state", 32'(s_state), 9);
    chk("beq_pcwc", 32'(s_out[0]), 1);
    chk("beq_aluop", 32'(s_out[5:4]), 1);
    chk("beq_pcsrc", 32'(s_out[3:2]), 1);

    // Illegal opcode goes from DECODE straight back to FETCH.
    step(6'h3F, 1, 0);
    chk("ill_fetch", 32'(s_state), 1);
    step(6'h3F, 1, 0);
    chk("ill_decode", 32'(s_state), 2);
    chk("ill_no_write", 32'(s_out & WRITE_MASK), 0);
    step(6'h23, 1, 0);
    chk("ill_back_fetch", 32'(s_state), 1);

    // Reset during a MEMRD stall.
    step(6'h23, 1, 0);
    step(6'h23, 1, 0);
    chk("lw2_memadr", 32'(s_state), 3);
    step(6'h23, 0, 0);
    chk("lw2_memrd", 32'(s_state), 4);
    step(6'h23, 0, 1);
    chk("lw2_memrd_stall", 32'(s_state), 4);
    step(6'h03, 1, 0);
    chk("rst_mid_state", 32'(s_state), 0);
    chk("rst_mid_memread", 32'(s_out[16]), 0);
    chk("rst_mid_no_write", 32'(s_out & WRITE_MASK), 0);

    // jal, or an illegal opcode when the feature is off.
    step(6'h03, 1, 0);
    chk("jal_fetch", 32'(s_state), 1);
    step(6'h03, 1, 0);
    chk("jal_decode", 32'(s_state), 2);
    step(6'h03, 1, 0);
`ifdef MIPS_CTRL_JAL_EN
    chk("jal_state", 32'(s_state), 13);
    chk("jal_regdst", 32'(s_out[13:12]), 2);
    chk("jal_memtoreg", 32'(s_out[11:10]), 2);
    chk("jal_pcwrite", 32'(s_out[1]), 1);
`else
    chk("jal_off_state", 32'(s_state), 1);
`endif

    // Randomized run. The opcode changes only while an instruction is being
    // fetched, which is when the IR may change.
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] op;
      logic       rdy;
      logic       rst;
      op = bus.opcode;
      if (exp_st <= 1) begin
        if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
        else                           op = ops[$urandom_range(0, 8)];
      end
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 149) == 0);
      step(op, rdy, rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
